// File: rtl/obi_ahbl_arbiter.sv
// Round-robin arbiter merging the instruction-fetch and data OBI ports onto one
// AHB-Lite master, issuing single NONSEQ transfers with one outstanding data phase.
module obi_ahbl_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          HRESP_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req,
  output logic                  instr_gnt,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_rvalid,
  output logic [DATA_WIDTH-1:0] instr_rdata,
  output logic                  instr_err,
  input  logic                  data_req,
  output logic                  data_gnt,
  input  logic                  data_we,
  input  logic [3:0]            data_be,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [2:0]            hburst,
  output logic                  hmastlock,
  output logic [3:0]            hprot,
  output logic [2:0]            hsize,
  output logic [1:0]            htrans,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam logic       OWN_INSTR = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  // Returns {hsize, haddr[1:0]} for a byte-enable pattern; odd patterns fall back to a word.
  function automatic logic [4:0] be_decode(input logic [3:0] be);
    logic [4:0] res;
    case (be)
      4'b1111: res = {3'b010, 2'b00};
      4'b0011: res = {3'b001, 2'b00};
      4'b1100: res = {3'b001, 2'b10};
      4'b0001: res = {3'b000, 2'b00};
      4'b0010: res = {3'b000, 2'b01};
      4'b0100: res = {3'b000, 2'b10};
      4'b1000: res = {3'b000, 2'b11};
      default: res = {3'b010, 2'b00};
    endcase
    return res;
  endfunction

  logic                  addr_hold_r;
  logic                  hold_owner_r;
  logic                  dph_valid_r;
  logic                  dph_owner_r;
  logic                  dph_we_r;
  logic [DATA_WIDTH-1:0] dph_wdata_r;
  logic                  last_owner_r;

  logic                  owner_valid_s;
  logic                  owner_s;
  logic                  accept_s;
  logic                  complete_s;
  logic [4:0]            be_map_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  err_s;

  // Owner selection: a stalled address phase keeps its owner, ties alternate.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_s       = OWN_INSTR;
    if (rst) begin
      owner_valid_s = 1'b0;
    end else if (addr_hold_r) begin
      owner_valid_s = 1'b1;
      owner_s       = hold_owner_r;
    end else if (instr_req && data_req) begin
      owner_valid_s = 1'b1;
      owner_s       = ~last_owner_r;
    end else if (instr_req) begin
      owner_valid_s = 1'b1;
      owner_s       = OWN_INSTR;
    end else if (data_req) begin
      owner_valid_s = 1'b1;
      owner_s       = OWN_DATA;
    end else begin
      owner_valid_s = 1'b0;
    end
  end

  // Address-phase control driven from the current owner's request.
  always_comb begin
    be_map_s = be_decode(data_be);
    htrans   = HT_IDLE;
    haddr    = '0;
    hwrite   = 1'b0;
    hsize    = 3'b010;
    hprot    = 4'b0000;
    if (owner_valid_s) begin
      htrans = HT_NONSEQ;
      if (owner_s == OWN_DATA) begin
        haddr  = {data_addr[ADDR_WIDTH-1:2], be_map_s[1:0]};
        hwrite = data_we;
        hsize  = be_map_s[4:2];
        hprot  = 4'b0011;
      end else begin
        haddr  = instr_addr;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hprot  = 4'b0010;
      end
    end else begin
      htrans = HT_IDLE;
    end
  end

  assign hburst     = 3'b000;
  assign hmastlock  = 1'b0;
  assign accept_s   = owner_valid_s & hready;
  assign complete_s = dph_valid_r & hready & ~rst;
  assign instr_gnt  = accept_s & (owner_s == OWN_INSTR);
  assign data_gnt   = accept_s & (owner_s == OWN_DATA);

  // Write responses carry no data; errors only propagate when the interconnect drives hresp.
  assign rdata_s      = dph_we_r ? '0 : hrdata;
  assign err_s        = hresp & HRESP_EN;
  assign instr_rvalid = complete_s & (dph_owner_r == OWN_INSTR);
  assign data_rvalid  = complete_s & (dph_owner_r == OWN_DATA);
  assign instr_rdata  = instr_rvalid ? rdata_s : '0;
  assign data_rdata   = data_rvalid ? rdata_s : '0;
  assign instr_err    = instr_rvalid & err_s;
  assign data_err     = data_rvalid & err_s;
  assign hwdata       = dph_valid_r ? dph_wdata_r : '0;

  // Arbitration history, address hold and the single outstanding data phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold_r  <= 1'b0;
      hold_owner_r <= OWN_INSTR;
      dph_valid_r  <= 1'b0;
      dph_owner_r  <= OWN_INSTR;
      dph_we_r     <= 1'b0;
      dph_wdata_r  <= '0;
      last_owner_r <= OWN_DATA;
    end else if (accept_s) begin
      last_owner_r <= owner_s;
      addr_hold_r  <= 1'b0;
      dph_valid_r  <= 1'b1;
      dph_owner_r  <= owner_s;
      dph_we_r     <= (owner_s == OWN_DATA) & data_we;
      dph_wdata_r  <= data_wdata;
    end else begin
      if (owner_valid_s) begin
        addr_hold_r  <= 1'b1;
        hold_owner_r <= owner_s;
      end
      if (hready) begin
        dph_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_obi_ahbl_arbiter.sv
// Directed and random bench for obi_ahbl_arbiter; a transaction-level model
// predicts every cycle. Two instances cover HRESP_EN = 0 and HRESP_EN = 1.
module tb_obi_ahbl_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata, hrdata;
  logic [3:0]  data_be;
  logic        hready, hresp;

  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata, haddr, hwdata;
  logic [2:0]  hburst, hsize;
  logic        hmastlock, hwrite;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  logic        d1_instr_gnt, d1_instr_rvalid, d1_instr_err, d1_data_gnt, d1_data_rvalid, d1_data_err;
  logic [31:0] d1_instr_rdata, d1_data_rdata, d1_haddr, d1_hwdata;
  logic [2:0]  d1_hburst, d1_hsize;
  logic        d1_hmastlock, d1_hwrite;
  logic [3:0]  d1_hprot;
  logic [1:0]  d1_htrans;

  always #5 clk = ~clk;

  obi_ahbl_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HRESP_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_addr(instr_addr),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .haddr(haddr), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .hsize(hsize),
    .htrans(htrans), .hwdata(hwdata), .hwrite(hwrite),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  obi_ahbl_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HRESP_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_gnt(d1_instr_gnt), .instr_addr(instr_addr),
    .instr_rvalid(d1_instr_rvalid), .instr_rdata(d1_instr_rdata), .instr_err(d1_instr_err),
    .data_req(data_req), .data_gnt(d1_data_gnt), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rvalid(d1_data_rvalid),
    .data_rdata(d1_data_rdata), .data_err(d1_data_err),
    .haddr(d1_haddr), .hburst(d1_hburst), .hmastlock(d1_hmastlock), .hprot(d1_hprot),
    .hsize(d1_hsize), .htrans(d1_htrans), .hwdata(d1_hwdata), .hwrite(d1_hwrite),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  typedef struct packed {
    logic        who;   // 0 instr, 1 data
    logic        we;
    logic [31:0] wdata;
  } resp_t;

  resp_t resp_q[$];
  int    grant_log[$];
  int    stuck_who;
  int    last_winner;
  int    n_checks;
  int    n_fails;
  bit    gi_last, gd_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict, compare, then advance the transaction model past the edge.
  task automatic cycle();
    int          win;
    bit          acc, comp;
    int          nbits;
    logic [2:0]  sz;
    logic [1:0]  off;
    logic [31:0] exp_rd;
    #1;
    win = -1;
    if (!rst) begin
      if (stuck_who >= 0)            win = stuck_who;
      else if (instr_req && data_req) win = 1 - last_winner;
      else if (instr_req)            win = 0;
      else if (data_req)             win = 1;
    end
    acc  = (win >= 0) && hready;
    comp = !rst && (resp_q.size() > 0) && hready;

    chk("htrans", 64'(htrans), (win >= 0) ? 64'd2 : 64'd0);
    chk("d1_htrans", 64'(d1_htrans), (win >= 0) ? 64'd2 : 64'd0);
    chk("hburst", 64'(hburst), 64'd0);
    chk("hmastlock", 64'(hmastlock), 64'd0);
    if (win == 0) begin
      chk("haddr_i", 64'(haddr), 64'(instr_addr));
      chk("hsize_i", 64'(hsize), 64'd2);
      chk("hprot_i", 64'(hprot), 64'd2);
      chk("hwrite_i", 64'(hwrite), 64'd0);
    end else if (win == 1) begin
      nbits = $countones(data_be);
      sz = 3'd2; off = 2'd0;
      if (nbits == 1) begin
        sz = 3'd0;
        for (int b = 0; b < 4; b++) if (data_be[b]) off = 2'(b);
      end else if (data_be == 4'b0011) begin
        sz = 3'd1; off = 2'd0;
      end else if (data_be == 4'b1100) begin
        sz = 3'd1; off = 2'd2;
      end
      chk("haddr_d", 64'(haddr), 64'({data_addr[31:2], off}));
      chk("hsize_d", 64'(hsize), 64'(sz));
      chk("hprot_d", 64'(hprot), 64'd3);
      chk("hwrite_d", 64'(hwrite), 64'(data_we));
    end
    chk("instr_gnt", 64'(instr_gnt), 64'(acc && win == 0));
    chk("data_gnt", 64'(data_gnt), 64'(acc && win == 1));
    chk("instr_rvalid", 64'(instr_rvalid), 64'(comp && resp_q[0].who == 1'b0));
    chk("data_rvalid", 64'(data_rvalid), 64'(comp && resp_q[0].who == 1'b1));
    chk("d1_instr_rvalid", 64'(d1_instr_rvalid), 64'(comp && resp_q[0].who == 1'b0));
    chk("hwdata", 64'(hwdata), (resp_q.size() > 0) ? 64'(resp_q[0].wdata) : 64'd0);
    if (comp) begin
      exp_rd = resp_q[0].we ? 32'd0 : hrdata;
      if (resp_q[0].who == 1'b0) begin
        chk("instr_rdata", 64'(instr_rdata), 64'(exp_rd));
        chk("instr_err_en0", 64'(instr_err), 64'd0);
        chk("instr_err_en1", 64'(d1_instr_err), 64'(hresp));
      end else begin
        chk("data_rdata", 64'(data_rdata), 64'(exp_rd));
        chk("data_err_en0", 64'(data_err), 64'd0);
        chk("data_err_en1", 64'(d1_data_err), 64'(hresp));
      end
    end else begin
      chk("err_idle", 64'({instr_err, data_err, d1_instr_err, d1_data_err}), 64'd0);
    end

    @(posedge clk);
    gi_last = acc && win == 0;
    gd_last = acc && win == 1;
    if (rst) begin
      resp_q.delete();
      stuck_who   = -1;
      last_winner = 1;
    end else begin
      if (comp) void'(resp_q.pop_front());
      if (acc) begin
        resp_q.push_back('{who: win[0], we: (win == 1) && data_we, wdata: data_wdata});
        last_winner = win;
        stuck_who   = -1;
        grant_log.push_back(win);
      end else if (win >= 0) begin
        stuck_who = win;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    stuck_who = -1; last_winner = 1;
    gi_last = 1'b0; gd_last = 1'b0;
    rst = 1'b1; instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    instr_addr = 32'd0; data_addr = 32'd0; data_wdata = 32'd0; data_be = 4'hF;
    hrdata = 32'd0; hready = 1'b1; hresp = 1'b0;
    @(negedge clk);

    // Reset state, with requests present
    instr_req = 1'b1; data_req = 1'b1;
    cycle(); cycle();
    instr_req = 1'b0; data_req = 1'b0;
    rst = 1'b0;

    // Single fetch
    instr_req = 1'b1; instr_addr = 32'h0000_0100;
    #1;
    chk("tp1_gnt", 64'(instr_gnt), 64'd1);
    chk("tp1_hsize", 64'(hsize), 64'd2);
    cycle();
    instr_req = 1'b0; hrdata = 32'hDEAD_BEEF;
    #1;
    chk("tp1_rdata", 64'(instr_rdata), 64'h0000_0000_DEAD_BEEF);
    cycle();

    // Contention after reset: alternate starting with instr
    rst = 1'b1; cycle(); rst = 1'b0;
    grant_log.delete();
    instr_req = 1'b1; data_req = 1'b1; data_we = 1'b0; data_be = 4'hF;
    instr_addr = 32'h0000_1000; data_addr = 32'h1000_0000;
    for (int k = 0; k < 4; k++) begin
      hrdata = 32'hA000_0000 + 32'(k);
      cycle();
      if (gi_last) instr_addr = instr_addr + 32'd4;
      if (gd_last) data_addr = data_addr + 32'd4;
    end
    instr_req = 1'b0; data_req = 1'b0;
    cycle();
    chk("tp2_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("tp2_order", 64'(grant_log[k]), 64'(k % 2));

    // Address wait states, instr arriving while data is held
    data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
    data_addr = 32'h3000_0010; data_wdata = 32'h1122_3344;
    hready = 1'b0;
    cycle();
    instr_req = 1'b1; instr_addr = 32'h0000_0200;
    cycle();
    chk("tp3_haddr_held", 64'(haddr), 64'h3000_0010);
    cycle();
    hready = 1'b1;
    cycle();
    data_req = 1'b0;
    #1;
    chk("tp3_instr_next", 64'(instr_gnt), 64'd1);
    cycle();
    instr_req = 1'b0;
    cycle();

    // Byte write
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0100;
    data_addr = 32'h2000_0000; data_wdata = 32'h00AB_0000;
    #1;
    chk("tp4_haddr", 64'(haddr), 64'h2000_0002);
    cycle();
    data_req = 1'b0; hrdata = 32'h5555_5555;
    #1;
    chk("tp4_hwdata", 64'(hwdata), 64'h00AB_0000);
    chk("tp4_rdata", 64'(data_rdata), 64'd0);
    cycle();

    // Error gating
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h4000_0000;
    cycle();
    data_req = 1'b0; hresp = 1'b1;
    cycle();
    hresp = 1'b0;

    // Reset during a data phase
    data_req = 1'b1; data_addr = 32'h4000_0100;
    cycle();
    data_req = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0; instr_req = 1'b1; data_req = 1'b1;
    #1;
    chk("tp6_instr_first", 64'(instr_gnt), 64'd1);
    cycle();
    instr_req = 1'b0;
    cycle();
    data_req = 1'b0;
    cycle();

    // Random traffic with protocol-abiding requesters
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 79) == 0);
      hready = ($urandom_range(0, 9) < 7);
      hrdata = $urandom();
      hresp  = ($urandom_range(0, 5) == 0);
      if (!instr_req || gi_last) begin
        instr_req  = $urandom_range(0, 1) == 1;
        instr_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!data_req || gd_last) begin
        data_req   = $urandom_range(0, 1) == 1;
        data_we    = $urandom_range(0, 1) == 1;
        data_be    = 4'($urandom_range(0, 15));
        data_addr  = $urandom();
        data_wdata = $urandom();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/obi_ahbl_arbiter.md
Name: obi_ahbl_arbiter

Overview:
- Shares the single AHB-Lite master port between the core's instruction-fetch and data OBI-style request ports.
- Sits between the core and the AHB-Lite interconnect's master input.
- Round-robin arbitration; converts req/gnt/rvalid transactions to AHB-Lite single NONSEQ transfers.
- Supports address/data-phase pipelining with one outstanding data phase.

Parameters:
ADDR_WIDTH, 32, address width of requesters and haddr
DATA_WIDTH, 32, data width (only 32 supported)
HRESP_EN, 0, 1: err outputs follow hresp; 0: err outputs forced 0 (interconnects that tie hresp high)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
instr_req  input  1  fetch request
instr_gnt  output  1  fetch address accepted
instr_addr  input  ADDR_WIDTH  fetch address (word aligned)
instr_rvalid  output  1  fetch data valid
instr_rdata  output  DATA_WIDTH  fetch data
instr_err  output  1  fetch error
data_req  input  1  data request
data_gnt  output  1  data address accepted
data_we  input  1  1 = write
data_be  input  4  byte enables
data_addr  input  ADDR_WIDTH  data address
data_wdata  input  DATA_WIDTH  write data
data_rvalid  output  1  data response valid (reads and writes)
data_rdata  output  DATA_WIDTH  read data
data_err  output  1  data error
haddr  output  ADDR_WIDTH  AHB address
hburst  output  3  always 3'b000 (SINGLE)
hmastlock  output  1  always 0
hprot  output  4  instr 4'b0010, data 4'b0011
hsize  output  3  transfer size
htrans  output  2  IDLE 2'b00 / NONSEQ 2'b10
hwdata  output  DATA_WIDTH  write data (data phase)
hwrite  output  1  write flag
hrdata  input  DATA_WIDTH  read data
hready  input  1  transfer ready
hresp  input  1  error response

Behaviour:
- Registered state: addr_hold (1), hold_owner (1), dph_valid (1), dph_owner (1), dph_we (1), dph_wdata (DATA_WIDTH), last_owner (1).
- Reset values: addr_hold 0, dph_valid 0, last_owner = data, so instr wins the first tie.
- Outputs during rst are combinationally forced: htrans IDLE, gnt 0, rvalid 0, err 0.
- Owner selection:
  - If addr_hold, owner = hold_owner.
  - Else if exactly one req is high, owner = that requester.
  - Else if both are high, owner = the requester not equal to last_owner.
  - Else no owner, and htrans = IDLE.
- Address phase (any owner):
  - htrans = NONSEQ; haddr, hwrite, hsize and hprot come from the owner's inputs.
  - instr: hwrite 0, hsize 3'b010.
- be to hsize/haddr[1:0] mapping (data):
  - 1111: word, offset 00.
  - 0011: half, 00. 1100: half, 10.
  - One-hot: byte, offset = index of the set bit.
  - Any other pattern: word, offset 00.
- Address acceptance:
  - When htrans = NONSEQ and hready = 1, assert the owner's gnt combinationally in the same cycle.
  - On that cycle: last_owner <= owner, addr_hold <= 0, dph_valid <= 1, dph_owner/dph_we <= owner/we, dph_wdata <= data_wdata.
- Wait states:
  - If NONSEQ is driven with hready = 0: addr_hold <= 1, hold_owner <= owner.
  - The address and control are held stable until hready = 1, even if the other requester asserts. Requesters keep req and address stable until gnt.
- Data phase:
  - hwdata = dph_wdata whenever dph_valid = 1, else 0.
  - When dph_valid && hready: pulse rvalid to dph_owner for exactly 1 cycle.
    - rdata = hrdata for reads, 0 for writes.
    - err = hresp & HRESP_EN.
  - dph_valid clears unless a new address is accepted in the same cycle.
- Pipelining: a new address phase may be accepted in the same cycle the previous data phase completes, giving back-to-back throughput of 1 transfer/cycle.
- Simultaneous completion and acceptance for the same requester: rvalid (old) and gnt (new) assert in the same cycle.
- Latency: with hready = 1, rvalid occurs 1 cycle after gnt.
- rst asserted mid-transfer:
  - All state returns to reset values and the pending data phase is dropped.
  - No rvalid is issued for it; the requester must reissue.

Test Plan:
- Single fetch: instr_req, addr 0x0000_0100, hready = 1 -> instr_gnt same cycle, htrans 2'b10, hsize 3'b010, hprot 4'b0010. Next cycle, hrdata 0xDEADBEEF -> instr_rvalid = 1, instr_rdata 0xDEADBEEF.
- Contention: both req held 4 cycles after reset -> grants in order instr, data, instr, data. Each rvalid goes to the matching port one cycle after its grant.
- Address wait: data_req write with hready low for 3 cycles, instr_req rising at cycle 1 -> haddr and hwrite stay at the data request and data_gnt fires only when hready = 1. instr is granted on the following cycle.
- Byte write: data_be 4'b0100, addr 0x2000_0000, wdata 0x00AB_0000 -> haddr 0x2000_0002, hsize 3'b000, hwrite 1. hwdata 0x00AB_0000 in the next cycle; data_rvalid with data_rdata 0.
- Error gating: hresp = 1 in data phase -> err 0 with HRESP_EN = 0, err 1 with HRESP_EN = 1.
- Reset mid data phase: assert rst in the cycle after gnt -> no rvalid; htrans IDLE. After release, instr wins the first tie.
